// File: rtl/led_pattern_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine_if
// Description : Button inputs and LED/mode/step outputs of the LED pattern
//               engine. Modport "master" is the button/board side and
//               "slave" is the engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_engine_if #(
   parameter int WIDTH = 4
);
   logic             button0;
   logic             button1;
   logic             button2;
   logic             button3;
   logic [WIDTH-1:0] leds;
   logic [1:0]       mode;
   logic             step;

   modport master (
      output button0, button1, button2, button3,
      input  leds, mode, step
   );

   modport slave (
      input  button0, button1, button2, button3,
      output leds, mode, step
   );
endinterface
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_engine
// Description : Four-button LED bar pattern engine. Buttons are synchronised
//               and rising-edge detected; STOP / ROTL / ROTR / BOUNCE
//               patterns advance one position per prescaler tick.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine #(
   parameter int WIDTH    = 4,
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 16
) (
   input  wire                     clk,
   input  wire                     rst,   // asynchronous, active-low
   led_pattern_engine_if.slave     bus
);

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_ROTL   = 2'd1,
      MODE_ROTR   = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_e;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] SEED_LOW  = WIDTH'(1);
   localparam logic [WIDTH-1:0] SEED_HIGH = SEED_LOW << (WIDTH - 1);

   // Button synchroniser and edge-detect pipeline; index n is buttonN.
   logic [3:0]       s1_q;
   logic [3:0]       s2_q;
   logic [3:0]       prev_q;
   logic [3:0]       press;

   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic             step_q, step_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             down_q, down_d;   // bounce direction: 0=up, 1=down
   logic             tick;

   wire  [3:0]       buttons = {bus.button3, bus.button2, bus.button1, bus.button0};

   // Two-flop synchroniser followed by a previous-sample flop for edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= 4'b0;
         s2_q   <= 4'b0;
         prev_q <= 4'b0;
      end else begin
         s1_q   <= buttons;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign press = s2_q & ~prev_q;
   assign tick  = (mode_q != MODE_IDLE) && (cnt_q == TICK_LAST);

   // Mode, pattern, prescaler and direction registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= MODE_IDLE;
         leds_q <= '0;
         step_q <= 1'b0;
         cnt_q  <= '0;
         down_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         leds_q <= leds_d;
         step_q <= step_d;
         cnt_q  <= cnt_d;
         down_q <= down_d;
      end
   end

   // Next state: a command (fixed priority 0>1>2>3) overrides any tick in the
   // same cycle; otherwise the prescaler runs and the pattern steps on tick.
   always_comb begin
      mode_d = mode_q;
      leds_d = leds_q;
      step_d = 1'b0;
      cnt_d  = cnt_q;
      down_d = down_q;

      if (press[0]) begin
         mode_d = MODE_IDLE;
         leds_d = '0;
         cnt_d  = '0;
         down_d = 1'b0;
      end else if (press[1]) begin
         mode_d = MODE_ROTL;
         leds_d = SEED_LOW;
         cnt_d  = '0;
      end else if (press[2]) begin
         mode_d = MODE_ROTR;
         leds_d = SEED_HIGH;
         cnt_d  = '0;
      end else if (press[3]) begin
         mode_d = MODE_BOUNCE;
         leds_d = SEED_LOW;
         cnt_d  = '0;
         down_d = 1'b0;
      end else if (mode_q == MODE_IDLE) begin
         cnt_d  = '0;
      end else if (tick) begin
         cnt_d  = '0;
         step_d = 1'b1;
         case (mode_q)
            MODE_ROTL: leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
            MODE_ROTR: leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
            MODE_BOUNCE: begin
               // Flip direction on the edge that lands on an end bit so each
               // end is lit for exactly one step.
               if (!down_q) begin
                  leds_d = leds_q << 1;
                  if (leds_d[WIDTH-1]) down_d = 1'b1;
               end else begin
                  leds_d = leds_q >> 1;
                  if (leds_d[0]) down_d = 1'b0;
               end
            end
            default: leds_d = '0;
         endcase
      end else begin
         cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   assign bus.leds = leds_q;
   assign bus.mode = mode_q;
   assign bus.step = step_q;

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
- Parametrised successor to the four-button LED shifter lab block.
- Drives a WIDTH-bit LED bar from four push-button commands: stop/clear, rotate left, rotate right, ping-pong bounce.
- Buttons are synchronised and rising-edge detected; pattern steps advance on a programmable prescaler tick.
- Sits between raw board buttons and the LED pins in the Lab 3 top level.

Parameters:
- WIDTH, 4, number of LEDs; legal range 2..32.
- TICK_DIV, 4, clock cycles per pattern step; legal range 1..2^16.
- CNT_W, 16, prescaler counter width; must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- button0  input  1  async; STOP command: go IDLE, clear LEDs.
- button1  input  1  async; ROTL command: rotate left from bit 0.
- button2  input  1  async; ROTR command: rotate right from bit WIDTH-1.
- button3  input  1  async; BOUNCE command: ping-pong from bit 0, moving up.
- leds  output  WIDTH  LED pattern, registered.
- mode  output  2  current mode: 0=IDLE, 1=ROTL, 2=ROTR, 3=BOUNCE; registered.
- step  output  1  one-cycle pulse in the cycle leds advanced; registered.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - leds=0, mode=IDLE, step=0.
  - Prescaler count=0, bounce direction=up.
  - Synchroniser and previous-sample flops=0.
- Reset mid-pattern aborts immediately; no step completes.
- A button held high through reset release yields exactly one press after release.
- Input path per button: two-flop synchroniser s1->s2, then prev<=s2. Press pulse = s2 & ~prev, one cycle wide.
- Command latency: button rises before edge k; s1 captures at k, s2 at k+1; mode/leds update at edge k+2.
- A button held high issues only one command. A new command requires release (≥1 sampled low) and re-press.
- Simultaneous presses use fixed priority button0 > button1 > button2 > button3. Lower presses in that cycle are dropped.
- Command effect, registered on the same edge:
  - STOP: mode=IDLE, leds=0.
  - ROTL: mode=ROTL, leds=1.
  - ROTR: mode=ROTR, leds=1<<(WIDTH-1).
  - BOUNCE: mode=BOUNCE, leds=1, direction=up.
  - Every command (including a repeat of the current mode) reloads the seed and clears the prescaler to 0. step=0 in a command cycle.
- Prescaler:
  - In IDLE: count held at 0, no ticks.
  - Otherwise: count increments each cycle. tick when count==TICK_DIV-1, then count wraps to 0.
  - First step lands TICK_DIV cycles after the command edge. With TICK_DIV=1, every cycle is a step.
- Step actions on tick (step=1 on the same edge leds changes):
  - ROTL: leds = {leds[WIDTH-2:0], leds[WIDTH-1]}; the MSB wraps to bit 0.
  - ROTR: leds = {leds[0], leds[WIDTH-1:1]}; bit 0 wraps to the MSB.
  - BOUNCE, up: shift left. On arriving at bit WIDTH-1, direction flips to down on that same edge.
  - BOUNCE, down: shift right. On arriving at bit 0, direction flips to up.
  - End bits are lit for exactly one step; no double dwell.
- A command arriving in a tick cycle wins; the step is discarded and step=0.
- Exactly one LED is lit in every non-IDLE mode; leds is one-hot or zero at all times.
- IDLE holds leds=0 indefinitely; step is never asserted in IDLE.

Test Plan:
Settings: WIDTH=4, TICK_DIV=4, clk period 20 ns.
- Reset: rst=0 at any time, including mid-BOUNCE -> leds=0000, mode=0, step=0 within the same cycle, no clock needed.
- button1 pulse one cycle -> mode=1, leds=0001 two edges later; then 0010, 0100, 1000, 0001 every 4 cycles, with step=1 on each change.
- button2 pulse -> leds=1000, then 0100, 0010, 0001, 1000 every 4 cycles. Holding button2 high for 40 cycles produces no reload beyond the first.
- button3 pulse -> leds sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-cycle spacing; each end bit lit for exactly one step.
- button0 and button1 asserted in the same cycle during ROTR -> mode=0, leds=0000, no further steps. Then a lone button1 press restarts at 0001.
- Rotate-mode press coincident with a tick (button3 timed so its command edge equals a step edge in ROTL) -> leds=0001, step=0, next step 4 cycles later.
